// File: rtl/rtc_tick_gen.sv
// Real-time tick generator: 32-bit phase accumulator yields rt_clk/rt_tick, with a 4-register bus slave (CTRL/INC/COUNT).
// Bus: one request per two cycles, ready one cycle after accept; valid is ignored while responding.
module rtc_tick_gen #(
    parameter logic [31:0] DEFAULT_INC = 32'h0015798F,
    parameter bit          DEFAULT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        rt_clk,
    output logic        rt_tick
);
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [31:0] inc_q, inc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tick_q, tick_d;

    logic        accept;
    logic        wr;
    logic [1:0]  sel;
    logic [32:0] sum;
    logic        carry;
    logic        unused_addr;

    assign sel         = address[3:2];
    assign wr          = |wstrb;
    assign unused_addr = ^{address[31:4], address[1:0]};
    assign sum         = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry       = en_q & sum[32];

    always_comb begin
        state_d = IDLE;
        accept  = 1'b0;
        if (state_q == IDLE && valid) begin
            state_d = RESP;
            accept  = 1'b1;
        end
    end

    // Register writes are ordered after the carry increment so a COUNT write wins.
    always_comb begin
        en_d    = en_q;
        inc_d   = inc_q;
        count_d = count_q;
        rdata_d = '0;
        acc_d   = en_q ? sum[31:0] : '0;
        tick_d  = carry;
        if (carry) begin
            count_d = count_q + 32'd1;
        end
        if (accept) begin
            case (sel)
                2'd0:    rdata_d = {31'b0, en_q};
                2'd1:    rdata_d = inc_q;
                2'd2:    rdata_d = count_q;
                default: rdata_d = '0;
            endcase
            if (wr) begin
                case (sel)
                    2'd0: begin
                        if (wstrb[0]) begin
                            en_d = wdata[0];
                        end
                    end
                    2'd1: begin
                        for (int i = 0; i < 4; i++) begin
                            if (wstrb[i]) begin
                                inc_d[8*i +: 8] = wdata[8*i +: 8];
                            end
                        end
                    end
                    2'd2:    count_d = '0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= DEFAULT_EN;
            inc_q   <= DEFAULT_INC;
            count_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            inc_q   <= inc_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            tick_q  <= tick_d;
        end
    end

    assign ready   = (state_q == RESP);
    assign rdata   = rdata_q;
    assign rt_clk  = acc_q[31];
    assign rt_tick = tick_q;
endmodule

// File: tb/tb_rtc_tick_gen.sv
// Bench for rtc_tick_gen: cycle-level behavioural model plus directed literal checks and random bus traffic.
module tb_rtc_tick_gen;
    localparam logic [31:0] DEF_INC = 32'h0015798F;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        rt_clk;
    logic        rt_tick;

    int checks   = 0;
    int failures = 0;

    rtc_tick_gen dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .address (address),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .ready   (ready),
        .rt_clk  (rt_clk),
        .rt_tick (rt_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register values and phase as plain integers.
    bit          m_live = 1'b0;
    bit          m_en, m_busy, m_tick;
    bit [31:0]   m_acc, m_inc, m_count, m_rdata;

    always @(posedge clk) begin : model
        longint unsigned total;
        bit              wrap, take;
        bit [31:0]       rd;
        if (reset) begin
            m_live  = 1'b1;
            m_en    = 1'b1;
            m_inc   = DEF_INC;
            m_count = 0;
            m_acc   = 0;
            m_busy  = 1'b0;
            m_tick  = 1'b0;
            m_rdata = 0;
        end else begin
            take  = !m_busy && valid;
            total = longint'(m_acc) + longint'(m_inc);
            wrap  = m_en && (total >= 64'h1_0000_0000);
            case (address[3:2])
                2'd0:    rd = {31'b0, m_en};
                2'd1:    rd = m_inc;
                2'd2:    rd = m_count;
                default: rd = 0;
            endcase
            if (take && wstrb != 4'h0 && address[3:2] == 2'd2) m_count = 0;
            else if (wrap)                                     m_count = m_count + 1;
            m_acc  = m_en ? 32'(total % 64'h1_0000_0000) : 32'h0;
            m_tick = wrap;
            if (take && wstrb != 4'h0) begin
                if (address[3:2] == 2'd0 && wstrb[0]) m_en = wdata[0];
                if (address[3:2] == 2'd1)
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) m_inc[8*b +: 8] = wdata[8*b +: 8];
            end
            m_rdata = take ? rd : 0;
            m_busy  = take;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("rt_clk",  {31'b0, rt_clk},  {31'b0, m_acc[31]});
            check("rt_tick", {31'b0, rt_tick}, {31'b0, m_tick});
            check("ready",   {31'b0, ready},   {31'b0, m_busy});
            check("rdata",   rdata,            m_rdata);
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r);
        @(negedge clk);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        r = rdata;
        check("bus_ready", {31'b0, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] r, a, d, cnt_hold;
        int          hi, tk;
        bit          found;
        reset = 1'b1; valid = 1'b0; address = 0; wdata = 0; wstrb = 0;
        repeat (3) @(negedge clk);
        check("rst_ready",   {31'b0, ready},   32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_rt_clk",  {31'b0, rt_clk},  32'd0);
        check("rst_rt_tick", {31'b0, rt_tick}, 32'd0);
        reset = 1'b0;

        bus(32'h0, 0, 4'h0, r); check("rd_ctrl",  r, 32'h1);
        bus(32'h4, 0, 4'h0, r); check("rd_inc",   r, DEF_INC);
        bus(32'h8, 0, 4'h0, r); check("rd_count", r, 32'h0);

        bus(32'h4, 32'h80FFFFFF, 4'b1000, r);
        bus(32'h4, 0, 4'h0, r); check("inc_lane3", r, 32'h8015798F);

        bus(32'h4, 32'h40000000, 4'hF, r);
        bus(32'h8, 32'hDEADBEEF, 4'h1, r);
        repeat (39) @(negedge clk);
        bus(32'h8, 0, 4'h0, r); check("count_40", r, 32'd10);
        hi = 0; tk = 0;
        repeat (8) begin
            @(negedge clk);
            hi += int'(rt_clk);
            tk += int'(rt_tick);
        end
        check("quarter_high", 32'(hi), 32'd4);
        check("quarter_tick", 32'(tk), 32'd2);

        bus(32'h0, 32'h0, 4'h1, r);
        @(negedge clk);
        check("dis_rt_clk",  {31'b0, rt_clk},  32'd0);
        check("dis_rt_tick", {31'b0, rt_tick}, 32'd0);
        cnt_hold = m_count;
        repeat (6) @(negedge clk);
        bus(32'h8, 0, 4'h0, r); check("dis_count_hold", r, cnt_hold);
        bus(32'h0, 32'h1, 4'h1, r);
        @(negedge clk); check("ren_clk_e1", {31'b0, rt_clk}, 32'd0);
        @(negedge clk); check("ren_clk_e2", {31'b0, rt_clk}, 32'd1);

        bus(32'h4, 32'h80000000, 4'hF, r);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (m_acc[31]) found = 1'b1;
        end
        check("carry_found", {31'b0, found}, 32'd1);
        valid = 1'b1; address = 32'h8; wdata = 32'h5; wstrb = 4'hF;
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
        check("clr_edge_tick", {31'b0, rt_tick}, 32'd1);
        bus(32'h8, 0, 4'h0, r); check("clr_wins",   r, 32'd0);
        bus(32'h8, 0, 4'h0, r); check("clr_then_1", r, 32'd1);

        bus(32'h4, 32'h00001234, 4'hF, r);
        bus(32'h0, 32'h0, 4'h1, r);
        @(negedge clk);
        valid = 1'b1; address = 32'h4; wstrb = 4'h0; reset = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("rst_drop_ready", {31'b0, ready}, 32'd0);
        check("rst_drop_rdata", rdata,          32'd0);
        reset = 1'b0;
        bus(32'h0, 0, 4'h0, r); check("rst_ctrl",  r, 32'h1);
        bus(32'h4, 0, 4'h0, r); check("rst_inc",   r, DEF_INC);
        bus(32'h8, 0, 4'h0, r); check("rst_count", r, 32'h0);

        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom % 40 == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            @(negedge clk);
            a = $urandom;
            case ($urandom % 4)
                0:       d = $urandom;
                1:       d = $urandom >> 4;
                2:       d = 32'h80000000;
                default: d = ($urandom % 8 == 0) ? 32'h0 : ($urandom >> 8);
            endcase
            if (a[3:2] == 2'd0) d[0] = ($urandom % 4 != 0);
            valid = 1'b1; address = a; wdata = d;
            wstrb = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
            repeat ($urandom_range(1, 2)) @(negedge clk);
            valid = 1'b0; wstrb = 4'h0;
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rtc_tick_gen.md
RTC_TICK_GEN -- requirements
Module: rtc_tick_gen

Interface
REQ-001 The block SHALL have parameter DEFAULT_INC, default 32'h0015798F, the reset value of INC (32.768 kHz from 100 MHz).
REQ-002 The block SHALL have parameter DEFAULT_EN, default 1, the reset value of CTRL.en.
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port valid, input, 1, request valid.
REQ-006 The block SHALL have port address, input, 32, byte address; only address[3:2] decoded.
REQ-007 The block SHALL have port wdata, input, 32, write data.
REQ-008 The block SHALL have port wstrb, input, 4, byte write strobes; 4'h0 means read.
REQ-009 The block SHALL have port rdata, output, 32, read data, valid while ready=1.
REQ-010 The block SHALL have port ready, output, 1, one-cycle response strobe.
REQ-011 The block SHALL have port rt_clk, output, 1, generated real-time clock, ~50% duty, glitch-free, for the timer block's rt_clk input.
REQ-012 The block SHALL have port rt_tick, output, 1, one-clk pulse per rt_clk period.

Function
REQ-013 Register map SHALL be: 0x0 CTRL (bit0 en, other bits read 0); 0x4 INC (32-bit RW); 0x8 COUNT (32-bit tick counter, read-only, any write clears it to 0); 0xC reads 0, writes ignored.
REQ-014 Bus FSM SHALL have states IDLE and RESP: IDLE with valid=1 → RESP; RESP → IDLE unconditionally; ready=1 only in RESP.
REQ-015 Accepted transactions SHALL occur at most every 2 cycles; valid is ignored in RESP.
REQ-016 Writes SHALL update only byte lanes with wstrb[i]=1, taking effect on the IDLE→RESP edge.
REQ-017 Read data SHALL be captured on the IDLE→RESP edge and held only during RESP; rdata SHALL be 0 when ready=0.
REQ-018 A 32-bit phase accumulator acc SHALL update acc ← acc+INC (mod 2^32) every clk while en=1.
REQ-019 rt_clk SHALL equal acc[31] directly (register output, no combinational logic).
REQ-020 rt_tick SHALL be registered: 1 for exactly the cycle after an edge where acc+INC carried out of bit 31.
REQ-021 COUNT SHALL increment by 1 (mod 2^32, wrapping 0xFFFFFFFF→0) on each clk edge where the carry occurs.
REQ-022 A COUNT write coincident with a carry SHALL leave COUNT=0 (clear wins).
REQ-023 en=0 SHALL force acc=0, rt_tick=0, rt_clk=0 on the next edge; COUNT holds.
REQ-024 Setting en 0→1 SHALL start accumulation from acc=0 on the following edge.
REQ-025 INC writes while enabled SHALL take effect on the next accumulation without clearing acc.
REQ-026 INC=0 SHALL hold acc and produce no ticks.

Reset
REQ-027 While reset=1 on a clk edge: acc=0, rt_clk=0, rt_tick=0, COUNT=0, INC=DEFAULT_INC, en=DEFAULT_EN, FSM=IDLE, ready=0, rdata=0.
REQ-028 Reset SHALL override a transaction in progress; an in-flight response SHALL be dropped with no ready pulse.

Verification
REQ-029 Reset release, read 0x0/0x4/0x8 → ready one cycle after each valid; rdata 0x1, 0x0015798F, 0x0.
REQ-030 Write INC=0x40000000 → rt_clk 2 cycles high, 2 low; rt_tick every 4th cycle; COUNT=10 after 40 enabled cycles.
REQ-031 Write INC byte-lane wstrb=4'b1000 with wdata=0x80FFFFFF on INC=0x0015798F → INC reads 0x8015798F.
REQ-032 Write CTRL=0 mid-run → next edge acc=0, rt_clk=0, no rt_tick; COUNT unchanged; CTRL=1 restarts from 0.
REQ-033 INC=0x80000000, COUNT write on a carry edge → COUNT reads 0, then increments every 2 cycles.
REQ-034 Assert reset during RESP → ready stays 0, all registers at REQ-027 values next cycle.
